// File: rtl/truth_scan_pkg.sv
// Shared state encoding, widths and helpers for the truth-table scanner.
package truth_scan_pkg;

  localparam int TT_WIDTH = 16;
  localparam int IDX_W    = 4;
  localparam int CNT_W    = 5;
  localparam int TMR_W    = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_t;

  function automatic logic is_last_idx(input logic [IDX_W-1:0] idx);
    return idx == IDX_W'(TT_WIDTH - 1);
  endfunction

endpackage

// File: rtl/truth_table_scanner_settle_timer.sv
// Loadable 4-bit down-counter that paces the settle wait between driving a vector and sampling it.
module settle_timer
  import truth_scan_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  input  logic             dec,
  output logic             zero,
  output logic             reach_zero
);

  logic [TMR_W-1:0] count;

  // NOTE: sequential state is written with <= only, so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero       = (count == '0);
  // High in the cycle whose decrement brings the count to zero.
  assign reach_zero = dec && !load && (count == TMR_W'(1));

endmodule

// File: rtl/truth_table_scanner.sv
// Walks a 4-input combinational function through all 16 minterms and captures its truth table.
// Optional build macro SCAN_PARITY_EN adds a registered parity output over the captured table.
module truth_table_scanner
  import truth_scan_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic                r,
  output logic                a,
  output logic                b,
  output logic                c,
  output logic                d,
  output logic                busy,
  output logic                done,
  output logic [TT_WIDTH-1:0] truth_table,
  output logic [CNT_W-1:0]    ones_count
`ifdef SCAN_PARITY_EN
  ,
  output logic                parity
`endif
);

  state_t           state;
  logic [IDX_W-1:0] idx;

  logic in_scan;
  logic accept;
  logic cancel;
  logic capture;
  logic tmr_load;
  logic tmr_dec;
  logic tmr_zero;
  logic tmr_reach;

  assign in_scan  = (state == S_SETTLE) || (state == S_SAMPLE);
  assign accept   = (state == S_IDLE) && start;
  assign cancel   = in_scan && abort;
  assign capture  = (state == S_SAMPLE) && !abort;
  assign tmr_load = accept || (capture && !is_last_idx(idx));
  assign tmr_dec  = (state == S_SETTLE) && !abort;

  // a is the most significant index bit, d the least.
  assign {a, b, c, d} = idx;

  settle_timer u_settle_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (tmr_load),
    .load_val   (TMR_W'(SETTLE)),
    .dec        (tmr_dec),
    .zero       (tmr_zero),
    .reach_zero (tmr_reach)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      idx         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      truth_table <= '0;
      ones_count  <= '0;
    end else begin
      done <= 1'b0;
      // Abort outranks every in-scan transition, including the final sample.
      if (cancel) begin
        state       <= S_IDLE;
        busy        <= 1'b0;
        idx         <= '0;
        truth_table <= '0;
        ones_count  <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start) begin
              state       <= S_SETTLE;
              busy        <= 1'b1;
              idx         <= '0;
              truth_table <= '0;
              ones_count  <= '0;
            end
          end
          S_SETTLE: begin
            // The zero check only matters for an out-of-range SETTLE of 0.
            if (tmr_reach || tmr_zero) begin
              state <= S_SAMPLE;
            end
          end
          S_SAMPLE: begin
            truth_table[idx] <= r;
            ones_count       <= ones_count + CNT_W'(r);
            if (is_last_idx(idx)) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              idx   <= idx + 1'b1;
              state <= S_SETTLE;
            end
          end
          S_DONE: begin
            state <= S_IDLE;
            idx   <= '0;
          end
          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
            idx   <= '0;
          end
        endcase
      end
    end
  end

`ifdef SCAN_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      parity <= 1'b0;
    end else if (accept || cancel) begin
      parity <= 1'b0;
    end else if (capture) begin
      parity <= parity ^ r;
    end
  end
`endif

endmodule

// File: tb/tb_truth_table_scanner.sv
// Directed bench for truth_table_scanner: one instance with SETTLE=1 and one with SETTLE=3.
module tb_truth_table_scanner;
  import truth_scan_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic        sel;
  logic [15:0] func;

  logic        start1, abort1, r1, a1, b1, c1, d1, busy1, done1;
  logic [15:0] tt1;
  logic [4:0]  ones1;
  logic        start3, abort3, r3, a3, b3, c3, d3, busy3, done3;
  logic [15:0] tt3;
  logic [4:0]  ones3;
`ifdef SCAN_PARITY_EN
  logic        par1, par3;
`endif

  int checks = 0;
  int errors = 0;

  assign start1 = start && !sel;
  assign abort1 = abort && !sel;
  assign start3 = start && sel;
  assign abort3 = abort && sel;
  assign r1     = func[{a1, b1, c1, d1}];
  assign r3     = func[{a3, b3, c3, d3}];

  truth_table_scanner #(.SETTLE(1)) dut1 (
    .clk         (clk),
    .reset       (reset),
    .start       (start1),
    .abort       (abort1),
    .r           (r1),
    .a           (a1),
    .b           (b1),
    .c           (c1),
    .d           (d1),
    .busy        (busy1),
    .done        (done1),
    .truth_table (tt1),
    .ones_count  (ones1)
`ifdef SCAN_PARITY_EN
    ,
    .parity      (par1)
`endif
  );

  truth_table_scanner #(.SETTLE(3)) dut3 (
    .clk         (clk),
    .reset       (reset),
    .start       (start3),
    .abort       (abort3),
    .r           (r3),
    .a           (a3),
    .b           (b3),
    .c           (c3),
    .d           (d3),
    .busy        (busy3),
    .done        (done3),
    .truth_table (tt3),
    .ones_count  (ones3)
`ifdef SCAN_PARITY_EN
    ,
    .parity      (par3)
`endif
  );

  wire [3:0]  idx_m  = sel ? {a3, b3, c3, d3} : {a1, b1, c1, d1};
  wire        busy_m = sel ? busy3 : busy1;
  wire        done_m = sel ? done3 : done1;
  wire [15:0] tt_m   = sel ? tt3 : tt1;
  wire [4:0]  ones_m = sel ? ones3 : ones1;
`ifdef SCAN_PARITY_EN
  wire        par_m  = sel ? par3 : par1;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Start is raised at a falling edge, so the following rising edge samples it.
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int edges);
    edges = 0;
    while (done_m !== 1'b1 && edges < budget) begin
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic wait_idx(input logic [3:0] target, input int budget, output int edges);
    edges = 0;
    while (idx_m !== target && edges < budget) begin
      @(negedge clk);
      edges++;
    end
  endtask

  task automatic check_result(input string tag, input logic [15:0] exp_tt,
                              input int exp_ones, input logic exp_par);
    check({tag, "_table"}, tt_m, exp_tt);
    check({tag, "_ones"}, ones_m, exp_ones);
`ifdef SCAN_PARITY_EN
    check({tag, "_parity"}, par_m, exp_par);
`else
    if (exp_par === 1'bx) $display("unexpected parity argument");
`endif
  endtask

  logic [15:0] pat_f    [5];
  int          pat_ones [5];
  logic        pat_par  [5];

  initial begin
    int e;
    int total;
    int seen;

    pat_f    = '{16'h1894, 16'hA5C3, 16'h8001, 16'h0000, 16'h7FFF};
    pat_ones = '{5, 8, 2, 0, 15};
    pat_par  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    sel   = 1'b0;
    func  = 16'h0000;

    @(negedge clk);
    check("rst_abcd", {a1, b1, c1, d1}, 4'h0);
    check("rst_busy", busy1, 1'b0);
    check("rst_done", done1, 1'b0);
    check("rst_table", tt1, 16'h0000);
    check("rst_ones", ones1, 5'd0);
    check("rst_state", 32'(dut1.state), 32'(S_IDLE));
`ifdef SCAN_PARITY_EN
    check("rst_parity", par1, 1'b0);
`endif
    reset = 1'b0;

    // Full scans of several functions at SETTLE=1.
    for (int p = 0; p < 5; p++) begin
      func = pat_f[p];
      pulse_start();
      check("scan_busy", busy_m, 1'b1);
      wait_done(40, e);
      check("scan_latency", e, 32);
      check_result("scan", pat_f[p], pat_ones[p], pat_par[p]);
      // Start presented during the DONE cycle must be ignored.
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("done_pulse_len", done_m, 1'b0);
      check("done_start_ignored", busy_m, 1'b0);
      repeat (3) @(negedge clk);
      check("hold_table", tt_m, pat_f[p]);
    end

    // Abort while idle leaves the held result untouched.
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("idle_abort_table", tt1, 16'h7FFF);

    // SETTLE=3 with r tied high: 64 edges and a saturating-free count of 16.
    @(negedge clk);
    sel  = 1'b1;
    func = 16'hFFFF;
    pulse_start();
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check("settle3_idx_stable", idx_m, 4'h0);
    end
    @(negedge clk);
    check("settle3_idx_next", idx_m, 4'h1);
    wait_done(80, e);
    check("settle3_latency", e + 4, 64);
    check_result("settle3", 16'hFFFF, 16, 1'b0);
    @(negedge clk);

    // Start while busy at index 5 neither restarts nor queues.
    sel  = 1'b0;
    func = 16'h1894;
    pulse_start();
    wait_idx(4'h5, 20, e);
    total = e;
    check("busy_idx5", idx_m, 4'h5);
    check("busy_abcd", {a1, b1, c1, d1}, 4'b0101);
    pulse_start();
    total += 2;
    wait_done(40, e);
    check("busy_restart_latency", total + e, 32);
    check_result("busy_restart", 16'h1894, 5, 1'b1);
    repeat (2) @(negedge clk);
    check("busy_no_queue", busy1, 1'b0);

    // Abort colliding with the final sample wins.
    pulse_start();
    repeat (31) @(negedge clk);
    check("abort_pre_state", 32'(dut1.state), 32'(S_SAMPLE));
    check("abort_pre_idx", idx_m, 4'hF);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_state", 32'(dut1.state), 32'(S_IDLE));
    check("abort_done", done1, 1'b0);
    check("abort_busy", busy1, 1'b0);
    check_result("abort", 16'h0000, 0, 1'b0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done1 === 1'b1) seen++;
    end
    check("abort_no_done", seen, 0);
    pulse_start();
    wait_done(40, e);
    check("after_abort_latency", e, 32);
    check_result("after_abort", 16'h1894, 5, 1'b1);
    repeat (2) @(negedge clk);

    // Asynchronous reset in the middle of a scan.
    pulse_start();
    wait_idx(4'h8, 40, e);
    check("pre_reset_idx", idx_m, 4'h8);
    check("pre_reset_ones", ones1, 5'd3);
    #2 reset = 1'b1;
    #1;
    check("async_rst_abcd", {a1, b1, c1, d1}, 4'h0);
    check("async_rst_busy", busy1, 1'b0);
    check("async_rst_table", tt1, 16'h0000);
    check("async_rst_ones", ones1, 5'd0);
    check("async_rst_state", 32'(dut1.state), 32'(S_IDLE));
    @(negedge clk);
    reset = 1'b0;
    check("after_rst_done", done1, 1'b0);
    pulse_start();
    check("after_rst_idx0", idx_m, 4'h0);
    wait_done(40, e);
    check("after_rst_latency", e, 32);
    check_result("after_rst", 16'h1894, 5, 1'b1);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
